ahb_resp_regfile: RTL and testbench

AHB_RESP_REGFILE -- requirements
Module: ahb_resp_regfile

---
 rtl/ahb_resp_regfile.sv | 145 ++++++++++++++
 tb/tb_ahb_resp_regfile.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_resp_regfile.sv
// AHB-Lite slave exposing NUM_REGS 32-bit byte-laned registers with WAIT_STATES per OKAY transfer.
// Define AHB_RESP_REGFILE_ERR_EN to give illegal transfers a two-cycle ERROR response.
module ahb_resp_regfile #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic        HREADYS,
  input  logic [31:0] HWDATAS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic [31:0] HRDATAS
);

  localparam bit         HasWait  = (WAIT_STATES > 0);
  localparam logic [1:0] WaitLoad = HasWait ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        act_q, legal_q, write_q;
  logic [3:0]  idx_q;
  logic [1:0]  off_q;
  logic [2:0]  size_q;

  logic        ready, accept, legal, commit;
  logic [3:0]  byte_en;
  logic [31:0] rd_word [16];

  logic unused_bits;
  assign unused_bits = ^{HADDRS[31:12], HTRANSS[0]};

  assign ready      = (state_q == StIdle) || (state_q == StErr2);
  assign HREADYOUTS = ready;
  assign accept     = HSELS & HTRANSS[1] & HREADYS & ready;

`ifdef AHB_RESP_REGFILE_ERR_EN
  assign HRESPS = (state_q == StErr1) || (state_q == StErr2);
`else
  assign HRESPS = 1'b0;
`endif

  always_comb begin
    legal = (HADDRS[11:6] == 6'd0) && (32'(HADDRS[5:2]) < NUM_REGS);
    case (HSIZES)
      3'd0:    ;
      3'd1:    legal = legal & ~HADDRS[0];
      3'd2:    legal = legal & (HADDRS[1:0] == 2'd0);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StErr2: begin
        state_d = StIdle;
        if (accept) begin
`ifdef AHB_RESP_REGFILE_ERR_EN
          if (!legal) begin
            state_d = StErr1;
          end else
`endif
          if (HasWait) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 2'd1;
      end
`ifdef AHB_RESP_REGFILE_ERR_EN
      StErr1:  state_d = StErr2;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      act_q   <= 1'b0;
      legal_q <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= 4'd0;
      off_q   <= 2'd0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // act_q marks a data phase in flight; it only moves on ready cycles.
      if (ready) act_q <= accept;
      if (accept) begin
        legal_q <= legal;
        write_q <= HWRITES;
        idx_q   <= HADDRS[5:2];
        off_q   <= HADDRS[1:0];
        size_q  <= HSIZES;
      end
    end
  end

  // An OKAY completion is the IDLE cycle of an active data phase.
  assign commit = act_q & legal_q & write_q & (state_q == StIdle);

  always_comb begin
    case (size_q)
      3'd0:    byte_en = 4'b0001 << off_q;
      3'd1:    byte_en = off_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  for (genvar g = 0; g < 16; g++) begin : g_reg
    if (g < NUM_REGS) begin : g_impl
      logic [31:0] word_q;
      always_ff @(posedge HCLK) begin
        if (HRESET) begin
          word_q <= '0;
        end else if (commit && (idx_q == 4'(g))) begin
          for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) word_q[8*b +: 8] <= HWDATAS[8*b +: 8];
          end
        end
      end
      assign rd_word[g] = word_q;
    end else begin : g_none
      assign rd_word[g] = '0;
    end
  end

  assign HRDATAS = (act_q & legal_q & ~write_q) ? rd_word[idx_q] : '0;

endmodule

// File: tb/tb_ahb_resp_regfile.sv
// Bench for ahb_resp_regfile: two instances (WS=0/12 regs, WS=2/16 regs) checked against a
// transaction-level model every cycle, plus literal expectations for the directed sequences.
module tb_ahb_resp_regfile;
`ifdef AHB_RESP_REGFILE_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk, rst;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic        hrdyo  [2];
  logic        hresp  [2];
  logic [31:0] hrdata [2];

  int total = 0;
  int bad   = 0;
  bit seen_edge = 0;

  ahb_resp_regfile #(.NUM_REGS(12), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSELS(hsel[0]), .HADDRS(haddr[0]), .HTRANSS(htrans[0]),
    .HWRITES(hwrite[0]), .HSIZES(hsize[0]), .HREADYS(hrdyo[0]), .HWDATAS(hwdata[0]),
    .HREADYOUTS(hrdyo[0]), .HRESPS(hresp[0]), .HRDATAS(hrdata[0])
  );

  ahb_resp_regfile #(.NUM_REGS(16), .WAIT_STATES(2)) u_dut1 (
    .HCLK(clk), .HRESET(rst), .HSELS(hsel[1]), .HADDRS(haddr[1]), .HTRANSS(htrans[1]),
    .HWRITES(hwrite[1]), .HSIZES(hsize[1]), .HREADYS(hrdyo[1]), .HWDATAS(hwdata[1]),
    .HREADYOUTS(hrdyo[1]), .HRESPS(hresp[1]), .HRDATAS(hrdata[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) seen_edge <= 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int nr_of(input int k);
    return (k == 0) ? 12 : 16;
  endfunction

  function automatic bit legal_of(input int k, input logic [31:0] a, input logic [2:0] s);
    int idx = int'(a[5:2]);
    int off = int'(a[1:0]);
    if (a[11:6] != 6'd0) return 1'b0;
    if (idx >= nr_of(k)) return 1'b0;
    if (s > 3'd2) return 1'b0;
    if ((off % (1 << s)) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input int size, input int off);
    logic [31:0] m;
    if (size == 0)      m = 32'h0000_00FF << (8 * off);
    else if (size == 1) m = 32'h0000_FFFF << (16 * (off / 2));
    else                m = 32'hFFFF_FFFF;
    return (old & ~m) | (wd & m);
  endfunction

  // Model: one outstanding data phase per DUT, described by its length and response kind.
  logic [31:0] m_regs [2][16];
  bit dp_v [2], dp_err [2], dp_legal [2], dp_wr [2];
  int dp_cyc [2], dp_low [2], dp_idx [2], dp_size [2], dp_off [2];

  always @(negedge clk) begin
    bit er;
    logic [31:0] erd;
    if (seen_edge) begin
      for (int k = 0; k < 2; k++) begin
        er  = !dp_v[k] || (dp_cyc[k] >= dp_low[k]);
        erd = (dp_v[k] && dp_legal[k] && !dp_wr[k]) ? m_regs[k][dp_idx[k]] : 32'd0;
        chk($sformatf("hreadyout[%0d]", k), {31'd0, hrdyo[k]}, {31'd0, er});
        chk($sformatf("hresp[%0d]", k), {31'd0, hresp[k]}, {31'd0, dp_v[k] && dp_err[k]});
        chk($sformatf("hrdata[%0d]", k), hrdata[k], erd);
        if (rst) begin
          dp_v[k] = 1'b0;
          for (int i = 0; i < 16; i++) m_regs[k][i] = 32'd0;
        end else begin
          if (dp_v[k] && er) begin
            if (dp_legal[k] && dp_wr[k])
              m_regs[k][dp_idx[k]] = merge(m_regs[k][dp_idx[k]], hwdata[k], dp_size[k], dp_off[k]);
            dp_v[k] = 1'b0;
          end else if (dp_v[k]) begin
            dp_cyc[k]++;
          end
          if (er && hsel[k] && htrans[k][1]) begin
            dp_v[k]     = 1'b1;
            dp_cyc[k]   = 0;
            dp_idx[k]   = int'(haddr[k][5:2]);
            dp_off[k]   = int'(haddr[k][1:0]);
            dp_size[k]  = int'(hsize[k]);
            dp_wr[k]    = hwrite[k];
            dp_legal[k] = legal_of(k, haddr[k], hsize[k]);
            dp_err[k]   = !dp_legal[k] && ErrEn;
            dp_low[k]   = dp_err[k] ? 1 : ws_of(k);
          end
        end
      end
    end
  end

  // Operation list for the pipelined master and per-op results.
  logic [31:0] op_addr [8], op_wdata [8];
  bit          op_wr [8];
  logic [2:0]  op_size [8];
  int          n_ops;
  logic [31:0] res_rdata [8];
  int          res_low [8];
  logic        res_resp [8];

  task automatic op(input logic [31:0] a, input bit w, input logic [2:0] s, input logic [31:0] d);
    op_addr[n_ops]  = a;
    op_wr[n_ops]    = w;
    op_size[n_ops]  = s;
    op_wdata[n_ops] = d;
    res_rdata[n_ops] = 32'hDEAD_BEEF;
    res_low[n_ops]   = -1;
    res_resp[n_ops]  = 1'bx;
    n_ops++;
  endtask

  task automatic present(input int k, input int a);
    if (a < n_ops) begin
      hsel[k] = 1'b1; htrans[k] = 2'b10; haddr[k] = op_addr[a];
      hwrite[k] = op_wr[a]; hsize[k] = op_size[a];
    end else begin
      hsel[k] = 1'b0; htrans[k] = 2'b00; hwrite[k] = 1'b0;
    end
  endtask

  task automatic run_ops(input int k);
    int a = 0, d = -1, lows = 0, cyc = 0;
    bit rdy;
    @(posedge clk); #1;
    present(k, a);
    while ((a < n_ops || d >= 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      rdy = hrdyo[k];
      if (d >= 0) begin
        if (!rdy) lows++;
        else begin
          res_rdata[d] = hrdata[k]; res_resp[d] = hresp[k]; res_low[d] = lows;
          d = -1; lows = 0;
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (a < n_ops) begin
          d = a; a++;
          hwdata[k] = op_wdata[d];
        end
        present(k, a);
      end
    end
    chk($sformatf("run_done[%0d]", k), {31'd0, (a >= n_ops && d < 0)}, 32'd1);
    n_ops = 0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; n_ops = 0;
    for (int k = 0; k < 2; k++) begin
      hsel[k] = 1'b0; haddr[k] = '0; htrans[k] = 2'b00;
      hwrite[k] = 1'b0; hsize[k] = 3'd0; hwdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", {31'd0, hrdyo[k]}, 32'd1);
      chk("reset_resp",  {31'd0, hresp[k]}, 32'd0);
      chk("reset_rdata", hrdata[k], 32'd0);
    end

    // Two wait states on both write and read.
    op(32'h008, 1'b1, 3'd2, 32'hA5A5_1234);
    op(32'h008, 1'b0, 3'd2, 32'd0);
    run_ops(1);
    chk("ws2_wr_low", res_low[0], 2);
    chk("ws2_rd_low", res_low[1], 2);
    chk("ws2_rd_data", res_rdata[1], 32'hA5A5_1234);
    chk("ws2_rd_resp", {31'd0, res_resp[1]}, 32'd0);

    // Back-to-back byte/halfword writes with immediate reads.
    op(32'h005, 1'b1, 3'd0, 32'h0000_EE00);
    op(32'h004, 1'b0, 3'd2, 32'd0);
    op(32'h006, 1'b1, 3'd1, 32'hBEEF_0000);
    op(32'h004, 1'b0, 3'd2, 32'd0);
    run_ops(0);
    chk("b2b_rd_low", res_low[1], 0);
    chk("b2b_byte_rd", res_rdata[1], 32'h0000_EE00);
    chk("b2b_half_rd", res_rdata[3], 32'hBEEF_EE00);

    // Misaligned halfword write must leave register 0 alone.
    op(32'h000, 1'b1, 3'd2, 32'h1122_3344);
    op(32'h003, 1'b1, 3'd1, 32'hFFFF_FFFF);
    op(32'h000, 1'b0, 3'd2, 32'd0);
    run_ops(0);
    chk("mis_wr_resp", {31'd0, res_resp[1]}, {31'd0, ErrEn});
    chk("mis_wr_low", res_low[1], ErrEn ? 1 : 0);
    chk("mis_reg0", res_rdata[2], 32'h1122_3344);

    // Index 16 read, then a NONSEQ held through the error and taken in the second cycle.
    op(32'h040, 1'b0, 3'd2, 32'd0);
    op(32'h000, 1'b0, 3'd2, 32'd0);
    run_ops(0);
    chk("oob_resp", {31'd0, res_resp[0]}, {31'd0, ErrEn});
    chk("oob_rdata", res_rdata[0], 32'd0);
    chk("after_err_resp", {31'd0, res_resp[1]}, 32'd0);
    chk("after_err_rdata", res_rdata[1], 32'h1122_3344);

    // NUM_REGS=12 edge, size 3 and misaligned word.
    op(32'h02C, 1'b1, 3'd2, 32'hCAFE_F00D);
    op(32'h030, 1'b1, 3'd2, 32'h1234_5678);
    op(32'h02C, 1'b0, 3'd2, 32'd0);
    op(32'h030, 1'b0, 3'd2, 32'd0);
    op(32'h000, 1'b0, 3'd3, 32'd0);
    op(32'h002, 1'b0, 3'd2, 32'd0);
    run_ops(0);
    chk("idx11_rd", res_rdata[2], 32'hCAFE_F00D);
    chk("idx12_rd", res_rdata[3], 32'd0);
    chk("idx12_resp", {31'd0, res_resp[3]}, {31'd0, ErrEn});
    chk("size3_rd", res_rdata[4], 32'd0);
    chk("misword_rd", res_rdata[5], 32'd0);

    // BUSY with select held: no effect, zero-wait OKAY.
    hsel[0] = 1'b1; htrans[0] = 2'b01; haddr[0] = 32'h000; hwrite[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_ready", {31'd0, hrdyo[0]}, 32'd1);
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b00; hwrite[0] = 1'b0;

    // Reset during WAIT discards the pending write.
    @(posedge clk); #1;
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h00C; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwrite[1] = 1'b0; hwdata[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op(32'h00C, 1'b0, 3'd2, 32'd0);
    op(32'h008, 1'b0, 3'd2, 32'd0);
    run_ops(1);
    chk("rst_wait_rd", res_rdata[0], 32'd0);
    chk("rst_clr_rd", res_rdata[1], 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
